// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter feeding the single-master memory bus switch.
// Optional ack watchdog is built only when MEM_ARB_TIMEOUT_EN is defined.
module mem_bus_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_stb_o,
  output logic            s_cyc_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  output logic [1:0]      grant_o
);

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  state_t r_state, w_next;
  logic   r_last;
  logic   w_tmo;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO = 8'(TIMEOUT_CYC);
  logic [7:0] r_cnt;

  // Zero while idle, so every grant starts counting from 0.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                         r_cnt <= '0;
    else if (r_state == IDLE)                           r_cnt <= '0;
    else if (!s_ack_i && r_cnt != TMO)                  r_cnt <= r_cnt + 8'd1;
  end

  assign w_tmo = (r_state != IDLE) && (r_cnt == TMO) && !s_ack_i;
`else
  // Watchdog compiled out: the limit can never trip.
  assign w_tmo = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == G0 && w_next == IDLE) r_last <= 1'b0;
      if (r_state == G1 && w_next == IDLE) r_last <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (m0_stb_i && m1_stb_i) w_next = r_last ? G0 : G1;
        else if (m0_stb_i)        w_next = G0;
        else if (m1_stb_i)        w_next = G1;
      end
      G0: if (s_ack_i || !m0_stb_i || w_tmo) w_next = IDLE;
      G1: if (s_ack_i || !m1_stb_i || w_tmo) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Slave bus follows the granted master combinationally; zero when idle.
  always_comb begin
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (r_state)
      G0: begin
        s_stb_o  = m0_stb_i & ~w_tmo;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_ack_o = s_ack_i;
        m0_err_o = w_tmo;
      end
      G1: begin
        s_stb_o  = m1_stb_i & ~w_tmo;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i;
        m1_err_o = w_tmo;
      end
      default: ;
    endcase
  end

  assign s_cyc_o  = s_stb_o;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign grant_o  = {r_state == G1, r_state == G0};

endmodule
